jump_event_recorder: RTL and testbench
======================================

JUMP_EVENT_RECORDER -- requirements
Module: jump_event_recorder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event buffer entries (power of two, 2..64).
REQ-002 SHALL have parameter HOLDOFF_LINES, default 2, lines after an accepted event during which further jumps are ignored (0 = no holdoff).
REQ-003 SHALL have port pixel_clock  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  capture enable.
REQ-006 SHALL have port lval  input  1  line-valid from the camera stream.
REQ-007 SHALL have port jump_detected  input  1  jump flag from the frequency jump detector.
REQ-008 SHALL have port frequency_code  input  2  new frequency class (00/01/10) reported alongside the jump.
REQ-009 SHALL have port event_valid  output  1  head event available.
REQ-010 SHALL have port event_ready  input  1  consumer accepts head event.
REQ-011 SHALL have port event_data  output  18  {frequency_code[1:0], line_number[15:0]}.
REQ-012 SHALL have port fill_level  output  clog2(FIFO_DEPTH)+1  stored event count.
REQ-013 SHALL have port overflow  output  1  sticky: event dropped because the buffer was full.
REQ-014 SHALL have port overflow_clear  input  1  clears overflow.
REQ-015 SHALL have port dropped_count  output  8  dropped-event count (see Configuration).

Function
REQ-016 SHALL keep a 16-bit line_number that increments on each lval rising edge while enable=1, wrapping 0xFFFF->0x0000, and holds while enable=0.
REQ-017 SHALL detect a jump as a rising edge of jump_detected (registered previous value); a level held high counts once.
REQ-018 SHALL accept a jump only when enable=1 and the holdoff counter is zero; otherwise ignore it with no state change.
REQ-019 SHALL, on acceptance, load the holdoff counter with HOLDOFF_LINES, decrementing it on each counted lval rising edge down to zero.
REQ-020 SHALL form the event word from frequency_code and line_number as sampled in the acceptance cycle (before any same-cycle line increment).
REQ-021 SHALL write an accepted event into the FIFO so that, from empty, event_valid rises exactly 1 cycle after the acceptance edge; no combinational bypass.
REQ-022 SHALL complete a transfer in each cycle with event_valid=1 and event_ready=1, popping the head.
REQ-023 SHALL hold event_data stable while event_valid=1 and event_ready=0.
REQ-024 SHALL, when an event is accepted while fill_level=FIFO_DEPTH and no pop occurs that cycle, drop it and set overflow.
REQ-025 SHALL, for simultaneous accept and pop while full, store the new event; fill_level unchanged.
REQ-026 SHALL, for simultaneous accept and pop with fill_level=1, pop the head and store the new event; fill_level stays 1.
REQ-027 SHALL ignore event_ready when empty; fill_level never underflows.
REQ-028 SHALL clear overflow on overflow_clear=1; a drop in the same cycle takes priority (overflow stays 1).
REQ-029 SHALL keep draining the FIFO while enable=0.

Reset
REQ-030 SHALL, on reset low, asynchronously clear line_number, holdoff counter, FIFO pointers, fill_level, event_valid, event_data, overflow, dropped_count and the jump_detected/lval edge registers to 0.
REQ-031 SHALL discard buffered events on reset; no event is emitted before a new acceptance after release.

Configuration
REQ-032 SHALL, with JUMP_EVENT_DROP_COUNT_EN defined, increment dropped_count on every dropped event, saturating at 0xFF, cleared by overflow_clear (a same-cycle drop leaves it at 1).
REQ-033 SHALL, without JUMP_EVENT_DROP_COUNT_EN, tie dropped_count to 0 and implement no counter logic.

Verification
REQ-034 SHALL cover: 5 lval pulses then jump pulse with frequency_code=01, event_ready=1 -> event_valid one cycle later, event_data=0x10005.
REQ-035 SHALL cover: HOLDOFF_LINES=2, jumps on line 3, line 4, line 5 -> events recorded only for lines 3 and 5.
REQ-036 SHALL cover: event_ready=0, 10 accepted jumps with FIFO_DEPTH=8 -> fill_level=8, overflow=1, dropped_count=2 (macro on) or 0 (macro off); drained data in order, first 8 events.
REQ-037 SHALL cover: full FIFO, accept with event_ready=1 same cycle -> fill_level stays 8, overflow stays 0.
REQ-038 SHALL cover: line_number at 0xFFFF, one lval edge then jump -> event_data line field 0x0000.
REQ-039 SHALL cover: reset asserted mid-drain with 3 stored events -> event_valid=0, fill_level=0 immediately, no events after release until a new jump.

Source files
------------

// File: rtl/jump_event_recorder.sv
// Records accepted frequency-jump events as {frequency_code, line_number} words in a small FIFO.
// Optional drop counter enabled by defining JUMP_EVENT_DROP_COUNT_EN.
module jump_event_recorder #(
    parameter int FIFO_DEPTH    = 8,
    parameter int HOLDOFF_LINES = 2
) (
    input  logic                        pixel_clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        lval,
    input  logic                        jump_detected,
    input  logic [1:0]                  frequency_code,
    output logic                        event_valid,
    input  logic                        event_ready,
    output logic [17:0]                 event_data,
    output logic [$clog2(FIFO_DEPTH):0] fill_level,
    output logic                        overflow,
    input  logic                        overflow_clear,
    output logic [7:0]                  dropped_count
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0] HOLD_LD  = 16'(HOLDOFF_LINES);

    logic          lval_q;
    logic          jump_q;
    logic [15:0]   line_q,    line_d;
    logic [15:0]   hold_q,    hold_d;
    logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [AW:0]   count_q,   count_d;
    logic          overflow_q, overflow_d;
    logic [17:0]   mem_q [FIFO_DEPTH];

    logic line_inc;
    logic accept;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign line_inc = lval & ~lval_q & enable;
    assign accept   = jump_detected & ~jump_q & enable & (hold_q == '0);
    assign full     = (count_q == FULL_LVL);
    assign pop      = (count_q != '0) & event_ready;
    // When full, a same-cycle pop frees the slot being written (wr_ptr == rd_ptr).
    assign push     = accept & (~full | pop);
    assign drop     = accept & full & ~pop;

    always_comb begin
        line_d     = line_q;
        hold_d     = hold_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (line_inc) begin
            line_d = line_q + 16'd1;
        end

        if (accept) begin
            hold_d = HOLD_LD;
        end else if (line_inc && (hold_q != '0)) begin
            hold_d = hold_q - 16'd1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            lval_q     <= 1'b0;
            jump_q     <= 1'b0;
            line_q     <= '0;
            hold_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            lval_q     <= lval;
            jump_q     <= jump_detected;
            line_q     <= line_d;
            hold_q     <= hold_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; the output mux masks stale entries while empty.
    always_ff @(posedge pixel_clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {frequency_code, line_q};
        end
    end

    assign event_valid = (count_q != '0);
    assign event_data  = event_valid ? mem_q[rd_ptr_q] : '0;
    assign fill_level  = count_q;
    assign overflow    = overflow_q;

`ifdef JUMP_EVENT_DROP_COUNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= '0;
        end else if (drop) begin
            if (overflow_clear) begin
                drop_cnt_q <= 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end else if (overflow_clear) begin
            drop_cnt_q <= '0;
        end
    end

    assign dropped_count = drop_cnt_q;
`else
    assign dropped_count = '0;
`endif

endmodule

// File: tb/tb_jump_event_recorder.sv
// Directed bench for jump_event_recorder with an expected-event scoreboard drained by a monitor.
module tb_jump_event_recorder;

    localparam int DEPTH   = 8;
    localparam int HOLDOFF = 2;
`ifdef JUMP_EVENT_DROP_COUNT_EN
    localparam int EXP_DROP = 2;
`else
    localparam int EXP_DROP = 0;
`endif

    logic        pixel_clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        lval = 1'b0;
    logic        jump_detected = 1'b0;
    logic [1:0]  frequency_code = 2'b00;
    logic        event_valid;
    logic        event_ready = 1'b0;
    logic [17:0] event_data;
    logic [3:0]  fill_level;
    logic        overflow;
    logic        overflow_clear = 1'b0;
    logic [7:0]  dropped_count;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [17:0] sb_q[$];
    logic [17:0] mon_exp;
    logic [15:0] m_line = '0;
    int          m_hold = 0;

    jump_event_recorder #(.FIFO_DEPTH(DEPTH), .HOLDOFF_LINES(HOLDOFF)) dut (
        .pixel_clock    (pixel_clock),
        .reset          (reset),
        .enable         (enable),
        .lval           (lval),
        .jump_detected  (jump_detected),
        .frequency_code (frequency_code),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_data     (event_data),
        .fill_level     (fill_level),
        .overflow       (overflow),
        .overflow_clear (overflow_clear),
        .dropped_count  (dropped_count)
    );

    always #5 pixel_clock = ~pixel_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Transfers happen at the next rising edge; sample at the falling edge.
    always @(negedge pixel_clock) begin
        if (reset && event_valid && event_ready) begin
            check("evt_expected", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                mon_exp = sb_q.pop_front();
                check("evt_data", event_data, mon_exp);
            end
        end
    end

    task automatic tick();
        @(posedge pixel_clock);
        #1;
    endtask

    task automatic lval_pulse();
        lval = 1'b1;
        tick();
        if (enable) begin
            m_line = m_line + 16'd1;
            if (m_hold > 0) m_hold--;
        end
        lval = 1'b0;
        tick();
    endtask

    task automatic jump(input logic [1:0] code, input bit store);
        bit acc;
        acc = enable && (m_hold == 0);
        jump_detected  = 1'b1;
        frequency_code = code;
        tick();
        jump_detected = 1'b0;
        if (acc) begin
            if (store) sb_q.push_back({code, m_line});
            m_hold = HOLDOFF;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        tick();
        sb_q.delete();
        m_line = '0;
        m_hold = 0;
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_empty(input int max_cycles);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || event_valid) && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain_left", sb_q.size(), 0);
        check("drain_valid", event_valid, 0);
    endtask

    initial begin
        #2;
        check("rst_valid", event_valid, 0);
        check("rst_fill", fill_level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", dropped_count, 0);
        check("rst_data", event_data, 0);
        tick();
        reset = 1'b1;
        tick();

        // basic capture, one-cycle latency
        enable = 1'b1;
        event_ready = 1'b1;
        for (int i = 0; i < 5; i++) lval_pulse();
        check("t1_pre_valid", event_valid, 0);
        jump(2'b01, 1'b1);
        check("t1_valid", event_valid, 1);
        check("t1_data", event_data, 18'h10005);
        wait_empty(10);

        // line counter holds and jumps are ignored while disabled
        lval_pulse();
        lval_pulse();
        enable = 1'b0;
        lval_pulse();
        jump(2'b10, 1'b1);
        tick();
        check("dis_fill", fill_level, 0);
        enable = 1'b1;
        lval_pulse();
        jump(2'b00, 1'b1);
        wait_empty(10);

        // holdoff: jumps on lines 3, 4, 5 -> events for 3 and 5
        apply_reset();
        for (int i = 0; i < 3; i++) lval_pulse();
        jump(2'b10, 1'b1);
        lval_pulse();
        jump(2'b01, 1'b1);
        lval_pulse();
        jump(2'b00, 1'b1);
        wait_empty(10);
        check("hold_fill", fill_level, 0);

        // overflow: 10 accepted with no consumer
        apply_reset();
        event_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            jump(2'((i + 1) % 3), i < DEPTH);
            check("ovf_head_stable", event_data, sb_q[0]);
            lval_pulse();
            lval_pulse();
        end
        check("ovf_fill", fill_level, DEPTH);
        check("ovf_flag", overflow, 1);
        check("ovf_dropcnt", dropped_count, EXP_DROP);
        event_ready = 1'b1;
        wait_empty(30);
        check("ovf_fill_drained", fill_level, 0);
        check("ovf_sticky", overflow, 1);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check("ovf_cleared", overflow, 0);
        check("ovf_dropcnt_clr", dropped_count, 0);

        // full FIFO, accept and pop in the same cycle
        event_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            jump(2'(i % 3), 1'b1);
            lval_pulse();
            lval_pulse();
        end
        check("full_fill", fill_level, DEPTH);
        event_ready = 1'b1;
        jump(2'b10, 1'b1);
        event_ready = 1'b0;
        check("full_ap_fill", fill_level, DEPTH);
        check("full_ap_ovf", overflow, 0);
        event_ready = 1'b1;
        wait_empty(30);

        // single entry, accept and pop in the same cycle
        event_ready = 1'b0;
        lval_pulse();
        lval_pulse();
        jump(2'b01, 1'b1);
        lval_pulse();
        lval_pulse();
        check("one_fill", fill_level, 1);
        event_ready = 1'b1;
        jump(2'b00, 1'b1);
        event_ready = 1'b0;
        check("one_ap_fill", fill_level, 1);
        event_ready = 1'b1;
        wait_empty(10);

        // line number wrap
        apply_reset();
        force dut.line_q = 16'hFFFF;
        #1;
        release dut.line_q;
        m_line = 16'hFFFF;
        lval_pulse();
        jump(2'b10, 1'b1);
        check("wrap_data", event_data, 18'h20000);
        wait_empty(10);

        // reset in the middle of a drain
        apply_reset();
        event_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            jump(2'b01, 1'b1);
            lval_pulse();
            lval_pulse();
        end
        check("mid_fill", fill_level, 3);
        event_ready = 1'b1;
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", event_valid, 0);
        check("mid_rst_fill", fill_level, 0);
        sb_q.delete();
        m_line = '0;
        m_hold = 0;
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_rst_quiet", event_valid, 0);
        end
        jump(2'b01, 1'b1);
        check("post_rst_valid", event_valid, 1);
        check("post_rst_data", event_data, 18'h10000);
        wait_empty(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
